credit_vc_rx_buffer: RTL
========================

Name: credit_vc_rx_buffer

Overview:
Receive-side endpoint of the credit-based VC link driven by a switch output port (single payload bus plus per-VC valid, per-VC credit grant back).
Each flit is stored in a per-VC FIFO, and each VC's head is presented to the downstream switch input (payload, valid, backpressure per VC).
One credit-grant pulse is returned upstream for every flit dequeued.
One instance sits on each switch input direction, between an upstream switch output and the local switch input.

Parameters:
N, DEFAULT_N, number of clients (pass-through, address sizing only)
A_W, DEFAULT_A_W, address width
D_W, DEFAULT_D_W, data width; flit width is A_W+D_W+1
VC_W, DEFAULT_VC_W, number of virtual channels
VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH, per-VC storage is VC_FIFO_DEPTH-1 entries; equals the sender's initial credit count per VC

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i  input  A_W+D_W+1  incoming flit payload (shared by all VCs)
i_v  input  VC_W  incoming valid, one bit per VC; at most one bit set per cycle
i_credit_gnt  output  VC_W  credit return to the sender, one-cycle pulse per dequeued flit
o  output  [VC_W][A_W+D_W+1]  head flit of each VC FIFO
o_v  output  VC_W  head valid per VC (FIFO non-empty)
o_bp  input  VC_W  backpressure from downstream; a head is consumed when o_v[k] & ~o_bp[k]
overflow_err  output  1  sticky error flag: write to a full VC
onehot_err  output  1  sticky error flag: more than one i_v bit set

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high (rst) and affects every register.
- Reset values: all FIFOs empty; o_v=0; i_credit_gnt=0; overflow_err=0; onehot_err=0; o=0.
- Push: when i_v[k]=1 and VC k holds fewer than VC_FIFO_DEPTH-1 entries at the start of the cycle, i is written to VC k.
- Overflow: when i_v[k]=1 and VC k is full at the start of the cycle, the flit is dropped, overflow_err sets, and FIFO state is unchanged. This holds even if a pop happens in the same cycle, because the credit for that slot has not yet been returned.
- Latency: a flit pushed in cycle t appears on o[k] with o_v[k]=1 in cycle t+1. There is no combinational path from i/i_v to o/o_v.
- Pop: when o_v[k]=1 and o_bp[k]=0, the head is removed at the clock edge and the next entry (if any) appears in the following cycle. o_bp[k] is ignored while o_v[k]=0.
- Simultaneous push and pop on the same VC (not full) is legal: occupancy is unchanged and order is preserved. On an empty VC, a push and a pop cannot coincide since o_v=0.
- Credit: i_credit_gnt[k] is registered and equals the pop condition of VC k from the previous cycle, i.e. exactly one pulse per dequeued flit, one cycle after the pop. No credits are emitted at reset; the sender initialises its counters to VC_FIFO_DEPTH-1.
- VCs are fully independent; several VCs may pop and grant in the same cycle.
- Multi-hot i_v: onehot_err sets. Each flagged VC still pushes the same payload, subject to its own full check. This is only diagnostic; behaviour is undefined in protocol terms.
- Pointers: wrap modulo VC_FIFO_DEPTH-1. Occupancy counters are $clog2(VC_FIFO_DEPTH) bits wide and never exceed VC_FIFO_DEPTH-1.
- Reset mid-operation: all stored flits and pending credit pulses are discarded. The sender must reset in the same cycle.
- Error flags clear only on rst.

Decomposition:
- common_pkg: use the existing DEFAULT_* constants. Add a typedef for the flit width helper, FLIT_W = A_W+D_W+1, as a localparam function if not already present.
- Sub-module credit_vc_fifo, instantiated VC_W times in a generate loop.
  - Registered-output FIFO of depth VC_FIFO_DEPTH-1 with ports push, pop, din, dout, empty, full.
  - The top level holds the credit-pulse register, error flags and one-hot check.
- Assertions, under SIMULATION:
  - no push to full;
  - i_v is $onehot0;
  - the sum of credits returned equals the sum of flits consumed.

Test Plan:
Config for all scenarios: VC_W=2, VC_FIFO_DEPTH=3 (2 entries/VC), A_W=3, D_W=8, so flits are 12 bits.
1. Basic: push 0xA5 on VC0 at t with o_bp=0 -> o_v[0]=1 and o[0]=0xA5 at t+1, pop at t+1, i_credit_gnt[0]=1 at t+2 only.
2. Fill/backpressure: o_bp=2'b11, push 0x001 then 0x002 on VC1 -> o_v[1] stays 1 with head 0x001 and no credits. Release o_bp[1] -> heads 0x001 then 0x002 are popped on consecutive cycles, and exactly two i_credit_gnt[1] pulses follow.
3. Overflow: with VC0 holding 2 entries, push 0x3FF on VC0 (pop concurrently) -> overflow_err=1 and 0x3FF never appears on o[0].
4. VC independence: VC0 full and blocked (o_bp[0]=1) while VC1 pushes 0x111 -> o[1]=0x111 the next cycle; VC0 is unaffected.
5. Concurrent push/pop on VC1 at occupancy 1 -> occupancy stays 1, FIFO order is preserved, one credit pulse.
6. Reset mid-stream: assert rst with both VCs non-empty and a credit pending -> next cycle all o_v=0, i_credit_gnt=0, error flags=0.
7. Multi-hot: i_v=2'b11 -> onehot_err=1.

Source files
------------

// File: rtl/common_pkg.sv
// Shared sizing constants and helpers for the credit-based VC link blocks.
package common_pkg;

    localparam int DEFAULT_N             = 8;
    localparam int DEFAULT_A_W           = 3;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 3;

    // A flit carries address, data and one framing bit.
    function automatic int flit_w(input int a_w, input int d_w);
        return a_w + d_w + 1;
    endfunction

    localparam int DEFAULT_FLIT_W = flit_w(DEFAULT_A_W, DEFAULT_D_W);

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/credit_vc_fifo.sv
// Single-VC flit FIFO; head is read straight from storage, so no input-to-output path exists.
module credit_vc_fifo
    import common_pkg::*;
#(
    parameter int W     = DEFAULT_FLIT_W,
    parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH - 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    // Fullness is judged at the start of the cycle: a same-cycle pop does not free the slot.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are unreachable because dout is gated by empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

`ifdef SIMULATION
    always @(posedge clk) begin
        if (!rst) assert (count <= CNT_W'(DEPTH)) else $error("credit_vc_fifo: push into full FIFO");
    end
`endif

endmodule

// File: rtl/credit_vc_rx_buffer.sv
// Receive endpoint of the credit VC link: per-VC FIFOs, one credit pulse per dequeued flit, sticky error flags.
module credit_vc_rx_buffer
    import common_pkg::*;
#(
    parameter int N             = DEFAULT_N,
    parameter int A_W           = DEFAULT_A_W,
    parameter int D_W           = DEFAULT_D_W,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    localparam int FLIT_W       = flit_w(A_W, D_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLIT_W-1:0]             i,
    input  logic [VC_W-1:0]               i_v,
    output logic [VC_W-1:0]               i_credit_gnt,
    output logic [VC_W-1:0][FLIT_W-1:0]   o,
    output logic [VC_W-1:0]               o_v,
    input  logic [VC_W-1:0]               o_bp,
    output logic                          overflow_err,
    output logic                          onehot_err
);

    if (A_W < $clog2(N)) begin : g_bad_a_w
        $error("credit_vc_rx_buffer: A_W too narrow to address N clients");
    end

    logic [VC_W-1:0] empty;
    logic [VC_W-1:0] full;
    logic [VC_W-1:0] pop;

    assign o_v = ~empty;
    assign pop = o_v & ~o_bp;

    for (genvar k = 0; k < VC_W; k++) begin : g_vc
        credit_vc_fifo #(
            .W     (FLIT_W),
            .DEPTH (VC_FIFO_DEPTH - 1)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (i_v[k]),
            .pop   (pop[k]),
            .din   (i),
            .dout  (o[k]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_credit_gnt <= '0;
            overflow_err <= 1'b0;
            onehot_err   <= 1'b0;
        end else begin
            i_credit_gnt <= pop;
            if (|(i_v & full)) overflow_err <= 1'b1;
            if (!$onehot0(i_v)) onehot_err <= 1'b1;
        end
    end

`ifdef SIMULATION
    int unsigned pop_total;
    int unsigned gnt_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_total <= 0;
            gnt_total <= 0;
        end else begin
            pop_total <= pop_total + 32'($countones(pop));
            gnt_total <= gnt_total + 32'($countones(i_credit_gnt));
        end
    end

    // Credits in flight are exactly the grants currently on the wire.
    always @(posedge clk) begin
        if (!rst) begin
            assert (gnt_total + 32'($countones(i_credit_gnt)) == pop_total)
                else $error("credit_vc_rx_buffer: credits returned differ from flits consumed");
            assert ($onehot0(i_v))
                else $warning("credit_vc_rx_buffer: multi-hot i_v");
        end
    end
`endif

endmodule
